// File: rtl/key_pkg.sv
// Shared types and constants for the key debounce block.
package key_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_fsm_e;

  // 20 ms of stable input at a 50 MHz clock.
  localparam int unsigned DEBOUNCE_20MS_50MHZ = 1000000;
  // Short window so simulations finish quickly.
  localparam int unsigned SIM_DEBOUNCE        = 8;

  // Raw pin level of a key that is not being pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, polarity fix, debounce counter and FSM,
// registered level and edge-pulse outputs.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CntW    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic        RelLevel = released_level(KEY_ACTIVE_LOW);

  logic            sync1_q, sync2_q;
  logic            pressed;
  key_fsm_e        fsm_q, fsm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            state_q, state_d;
  logic            press_q, press_d;
  logic            release_q, release_d;

  // Metastability guard: pins are asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RelLevel;
      sync2_q <= RelLevel;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Normalise so that 1 always means pressed.
  assign pressed = sync2_q ^ KEY_ACTIVE_LOW;

  // Next-state logic: a change is accepted only after DEBOUNCE_CYCLES matching samples.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (fsm_q)
      RELEASED: begin
        if (pressed) begin
          fsm_d = PRESS_PENDING;
          cnt_d = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_PENDING: begin
        if (!pressed) begin
          // Bounce: drop back without any output change.
          fsm_d = RELEASED;
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          fsm_d   = PRESSED;
          cnt_d   = '0;
          state_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          fsm_d = RELEASE_PENDING;
          cnt_d = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE_PENDING: begin
        if (pressed) begin
          fsm_d = PRESSED;
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          fsm_d     = RELEASED;
          cnt_d     = '0;
          state_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  // FSM, counter and registered outputs; reset discards any pending count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= RELEASED;
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS independent push-buttons for the LED sequencer.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  // One fully independent channel per key.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_raw_i(key_in[g]),
      .state_o  (key_state[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scenario bench for key_debounce with an 8-cycle debounce window.
module tb_key_debounce;

  localparam int unsigned Lat = 10;  // pin change to output, in edges

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_in;
  logic [3:0] key_state, key_press, key_release;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned at;
    logic [3:0]  st;
    logic [3:0]  pr;
    logic [3:0]  rl;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] exp_state = 4'b0000;
  logic [3:0] exp_p, exp_r;

  key_debounce #(
    .NUM_KEYS       (4),
    .DEBOUNCE_CYCLES(8),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); exp_state = e.st; exp_p = e.pr; exp_r = e.rl;
      end else begin
        exp_p = 4'b0; exp_r = 4'b0;
      end
      checks++;
      if (key_state !== exp_state) begin
        errors++; $display("FAIL reset.state cyc %0d got %b want %b", cyc, key_state, exp_state);
      end
      checks++;
      if (key_press !== exp_p) begin
        errors++; $display("FAIL reset.press cyc %0d got %b want %b", cyc, key_press, exp_p);
      end
      checks++;
      if (key_release !== exp_r) begin
        errors++; $display("FAIL reset.release cyc %0d got %b want %b", cyc, key_release, exp_r);
      end
      if (i == 3) begin
        rst = 1'b0;
        sb.push_back('{cyc + Lat, 4'b1111, 4'b1111, 4'b0000});
      end else if (i == 16) begin
        key_in = 4'b1111;
        sb.push_back('{cyc + Lat, 4'b0000, 4'b0000, 4'b1111});
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL reset.pending got %0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); exp_state = e.st; exp_p = e.pr; exp_r = e.rl;
      end else begin
        exp_p = 4'b0; exp_r = 4'b0;
      end
      checks++;
      if (key_state !== exp_state) begin
        errors++; $display("FAIL press.state cyc %0d got %b want %b", cyc, key_state, exp_state);
      end
      checks++;
      if (key_press !== exp_p) begin
        errors++; $display("FAIL press.press cyc %0d got %b want %b", cyc, key_press, exp_p);
      end
      checks++;
      if (key_release !== exp_r) begin
        errors++; $display("FAIL press.release cyc %0d got %b want %b", cyc, key_release, exp_r);
      end
      if (i == 0) begin
        key_in[0] = 1'b0;
        sb.push_back('{cyc + Lat, 4'b0001, 4'b0001, 4'b0000});
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL press.pending got %0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); exp_state = e.st; exp_p = e.pr; exp_r = e.rl;
      end else begin
        exp_p = 4'b0; exp_r = 4'b0;
      end
      checks++;
      if (key_state !== exp_state) begin
        errors++; $display("FAIL bounce.state cyc %0d got %b want %b", cyc, key_state, exp_state);
      end
      checks++;
      if (key_press !== exp_p) begin
        errors++; $display("FAIL bounce.press cyc %0d got %b want %b", cyc, key_press, exp_p);
      end
      checks++;
      if (key_release !== exp_r) begin
        errors++; $display("FAIL bounce.release cyc %0d got %b want %b", cyc, key_release, exp_r);
      end
      if (i < 30) begin
        key_in[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      end else if (i == 30) begin
        key_in[1] = 1'b0;
        sb.push_back('{cyc + Lat, 4'b0011, 4'b0010, 4'b0000});
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL bounce.pending got %0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); exp_state = e.st; exp_p = e.pr; exp_r = e.rl;
      end else begin
        exp_p = 4'b0; exp_r = 4'b0;
      end
      checks++;
      if (key_state !== exp_state) begin
        errors++; $display("FAIL glitch.state cyc %0d got %b want %b", cyc, key_state, exp_state);
      end
      checks++;
      if (key_press !== exp_p) begin
        errors++; $display("FAIL glitch.press cyc %0d got %b want %b", cyc, key_press, exp_p);
      end
      checks++;
      if (key_release !== exp_r) begin
        errors++; $display("FAIL glitch.release cyc %0d got %b want %b", cyc, key_release, exp_r);
      end
      // Low for exactly 7 edges: one short of acceptance.
      if (i == 0) key_in[2] = 1'b0;
      else if (i == 7) key_in[2] = 1'b1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL glitch.pending got %0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); exp_state = e.st; exp_p = e.pr; exp_r = e.rl;
      end else begin
        exp_p = 4'b0; exp_r = 4'b0;
      end
      checks++;
      if (key_state !== exp_state) begin
        errors++; $display("FAIL b2b.state cyc %0d got %b want %b", cyc, key_state, exp_state);
      end
      checks++;
      if (key_press !== exp_p) begin
        errors++; $display("FAIL b2b.press cyc %0d got %b want %b", cyc, key_press, exp_p);
      end
      checks++;
      if (key_release !== exp_r) begin
        errors++; $display("FAIL b2b.release cyc %0d got %b want %b", cyc, key_release, exp_r);
      end
      if (i == 0) begin
        key_in[1] = 1'b1;
        sb.push_back('{cyc + Lat, 4'b0001, 4'b0000, 4'b0010});
      end else if (i == 13) begin
        key_in[0] = 1'b1;
        key_in[3] = 1'b0;
        sb.push_back('{cyc + Lat, 4'b1000, 4'b1000, 4'b0001});
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b.pending got %0d want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (sb.size() != 0 && sb[0].at == cyc) begin
        e = sb.pop_front(); exp_state = e.st; exp_p = e.pr; exp_r = e.rl;
      end else begin
        exp_p = 4'b0; exp_r = 4'b0;
      end
      checks++;
      if (key_state !== exp_state) begin
        errors++; $display("FAIL rstmid.state cyc %0d got %b want %b", cyc, key_state, exp_state);
      end
      checks++;
      if (key_press !== exp_p) begin
        errors++; $display("FAIL rstmid.press cyc %0d got %b want %b", cyc, key_press, exp_p);
      end
      checks++;
      if (key_release !== exp_r) begin
        errors++; $display("FAIL rstmid.release cyc %0d got %b want %b", cyc, key_release, exp_r);
      end
      if (i == 0) begin
        key_in[1] = 1'b0;
      end else if (i == 7) begin
        // Channel 1 count has reached 5 here.
        rst = 1'b1;
        exp_state = 4'b0000;
      end else if (i == 10) begin
        rst = 1'b0;
        // Keys 1 and 3 are both held through reset.
        sb.push_back('{cyc + Lat, 4'b1010, 4'b1010, 4'b0000});
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rstmid.pending got %0d want 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 4'b0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream input stage for the board LED logic.
- Takes NUM_KEYS raw mechanical push-buttons (asynchronous, bouncing, active-low on the board) and turns them into clean signals for the LED pattern/mode logic:
  - a synchronized, debounced pressed/released level per key;
  - single-cycle press and release pulses per key.
- Sits between the board pins and the LED sequencer, which uses the press pulses to step or pause the LED pattern.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, stable-input cycles required before a change is accepted (20 ms at 50 MHz). Must be ≥ 2.
- KEY_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  input  1  system clock, 50 MHz nominal
- rst  input  1  asynchronous, active-high reset
- key_in  input  NUM_KEYS  raw key pins, asynchronous to clk
- key_state  output  NUM_KEYS  debounced level, 1 = pressed (polarity already normalised)
- key_press  output  NUM_KEYS  1-cycle pulse on an accepted released→pressed change
- key_release  output  NUM_KEYS  1-cycle pulse on an accepted pressed→released change

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst). All flops clear on rst assertion, independent of clk.
- Reset values:
  - key_state = 0, key_press = 0, key_release = 0.
  - Sync flops = released pin level (1 if KEY_ACTIVE_LOW, else 0).
  - Counters = 0, FSM = RELEASED.
- Synchronizer:
  - Per key, 2-flop synchronizer on key_in.
  - Then polarity normalisation: pressed = sync2 XOR KEY_ACTIVE_LOW.
- Counter:
  - Width = $clog2(DEBOUNCE_CYCLES).
  - Saturation is never reached: the counter clears on commit or on match.
- Per-key FSM, 4 states:
  - RELEASED:
    - pressed = 1 → PRESS_PENDING, cnt ← 1.
    - else cnt ← 0.
  - PRESS_PENDING:
    - pressed = 0 → RELEASED, cnt ← 0 (bounce rejected).
    - pressed = 1 and cnt == DEBOUNCE_CYCLES-1 → PRESSED, cnt ← 0, key_state ← 1, key_press ← 1.
    - else cnt ← cnt+1.
  - PRESSED: mirror of RELEASED, moving to RELEASE_PENDING on pressed = 0.
  - RELEASE_PENDING:
    - pressed = 1 → PRESSED, cnt ← 0.
    - pressed = 0 and cnt == DEBOUNCE_CYCLES-1 → RELEASED, key_state ← 0, key_release ← 1.
    - else cnt ← cnt+1.
- Outputs:
  - key_state is 1 exactly in PRESSED and RELEASE_PENDING; it is registered.
  - key_press and key_release are registered, high for exactly one cycle, and default to 0 every other cycle.
- Latency:
  - The raw pin changes before rising edge 1 and stays stable.
  - key_state changes, and the matching pulse asserts, at edge DEBOUNCE_CYCLES+2.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change and no pulse.
- Pulse exclusivity: press and release pulses never assert together on one key. Channels are fully independent; any combination of keys may pulse in the same cycle.
- Reset mid-operation: pending counts are discarded and no pulse is emitted.
  - If a key is held through reset release, key_press fires at edge DEBOUNCE_CYCLES+2 after rst deasserts.
  - This is the intended power-on behaviour.
- No combinational path from key_in to any output.

Decomposition:
- Package key_pkg holds:
  - the FSM state enum: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING (2-bit);
  - default debounce constants: DEBOUNCE_20MS_50MHZ = 1000000, SIM_DEBOUNCE = 8.
- Sub-module key_debounce_ch is one channel: synchronizer, counter, FSM and output registers.
- key_debounce instantiates NUM_KEYS copies via generate; the top level has no other logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, KEY_ACTIVE_LOW=1, NUM_KEYS=4.
1. Reset: rst=1 with key_in=4'b0000 (all pressed), deassert at t0 → outputs 0 during reset; key_state=4'b1111 and key_press=4'b1111 for one cycle at edge 10 after t0.
2. Clean press: key_in[0] 1→0 and held → key_state[0]=1 and key_press[0]=1 at edge 10; key_press[0]=0 at edge 11; no release pulse.
3. Bounce: key_in[1] toggles 0/1 every 3 cycles for 30 cycles, then holds 0 → no pulses during bouncing; single key_press[1] 10 edges after the final settle.
4. Short glitch: key_in[2] low for 7 cycles, then high → key_state[2] stays 0, no pulses at all.
5. Release plus simultaneous events: key 0 pressed; then key_in[0]→1 and key_in[3]→0 on the same edge → on edge 10, key_release[0]=1 and key_press[3]=1 in the same cycle; key_state=4'b1000.
6. Reset mid-debounce: key_in[1]→0, assert rst at count 5, release rst with the key still held → no pulse before reset; key_press[1] at edge 10 after rst deasserts.
